md_sched: RTL and testbench

- Multiply/divide sequencer for the 5-stage pipeline.
- Accepts one MD operation from the Execute stage and computes the result up front.
- Holds the result hidden for a fixed operation latency, drives `busy`, and commits HI/LO at the end.
- Generates the Decode-stage stall for any HI/LO-dependent instruction while an operation is pending.

---
 rtl/md_sched.sv | 125 ++++++++++++
 tb/tb_md_sched.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/md_sched.sv
// Multiply/divide sequencer: computes the MD result at start, hides it for a
// fixed latency while busy, then commits HI/LO; also drives the Decode stall.
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_md_use,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        stall_d
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  // RUN encodes as 1, so busy is simply the state flop.
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   pend_hi;
  logic [31:0]   pend_lo;
  logic          pend_wr;

  logic               is_md;
  logic               is_div;
  logic               div_zero;
  logic signed [63:0] op_a_s;
  logic signed [63:0] op_b_s;
  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        div_b_s;
  logic [31:0]        div_b_u;
  logic signed [31:0] quo_s;
  logic signed [31:0] rem_s;
  logic [31:0]        quo_u;
  logic [31:0]        rem_u;
  logic [63:0]        res;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    is_md    = (md_op >= OP_MULT) && (md_op <= OP_DIVU);
    is_div   = (md_op == OP_DIV) || (md_op == OP_DIVU);
    div_zero = (rt_val == 32'd0);

    op_a_s = {{32{rs_val[31]}}, rs_val};
    op_b_s = {{32{rt_val[31]}}, rt_val};
    prod_s = op_a_s * op_b_s;
    prod_u = {32'd0, rs_val} * {32'd0, rt_val};

    // Divide by 1 instead of 0 or of -1 on the 0x80000000 overflow case: the
    // zero case is never committed and the overflow case then yields the
    // architected quotient 0x80000000 with remainder 0.
    div_b_s = (div_zero || (rs_val == 32'h8000_0000 && rt_val == 32'hFFFF_FFFF))
              ? 32'd1 : rt_val;
    div_b_u = div_zero ? 32'd1 : rt_val;
    quo_s   = $signed(rs_val) / $signed(div_b_s);
    rem_s   = $signed(rs_val) % $signed(div_b_s);
    quo_u   = rs_val / div_b_u;
    rem_u   = rs_val % div_b_u;

    res = 64'd0;
    case (md_op)
      OP_MULT:  res = prod_s;
      OP_MULTU: res = prod_u;
      OP_DIV:   res = {rem_s, quo_s};
      OP_DIVU:  res = {rem_u, quo_u};
      default:  res = 64'd0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the pending result registers are reset too, so nothing stale survives an aborted operation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_wr <= 1'b0;
    end else if (state == IDLE) begin
      if (start && is_md) begin
        pend_hi <= res[63:32];
        pend_lo <= res[31:0];
        pend_wr <= !(is_div && div_zero);
        cnt     <= is_div ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
        state   <= RUN;
      end else if (start && md_op == OP_MTHI) begin
        hi <= rs_val;
      end else if (start && md_op == OP_MTLO) begin
        lo <= rs_val;
      end
    end else begin
      if (cnt == '0) begin
        if (pend_wr) begin
          hi <= pend_hi;
          lo <= pend_lo;
        end
        state <= IDLE;
      end else begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  assign busy    = (state == RUN);
  assign stall_d = d_md_use & (busy | (start & is_md));

endmodule

// File: tb/tb_md_sched.sv
// Self-checking bench for md_sched: directed vector table, hand-written
// stall/reset sequences and random operations against a 64-bit arithmetic model.
module tb_md_sched;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        d_md_use;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        stall_d;

  int checks   = 0;
  int failures = 0;

  // Architected HI/LO as the bench believes them to be.
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e_hi;
    logic [31:0] e_lo;
    int          cycles;
  } vec_t;

  vec_t vecs[12];

  always #5 clk = ~clk;

  md_sched #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .md_op    (md_op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .d_md_use (d_md_use),
    .busy     (busy),
    .hi       (hi),
    .lo       (lo),
    .stall_d  (stall_d)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Architectural model: returns busy length, outputs resulting HI/LO.
  function automatic int model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] ih, input logic [31:0] il,
                                  output logic [31:0] oh, output logic [31:0] ol);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    logic [63:0]     t;
    logic [63:0]     r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    oh = ih;
    ol = il;
    case (op)
      3'd1: begin t = sa * sb; oh = t[63:32]; ol = t[31:0]; return MULT_CYCLES; end
      3'd2: begin t = ua * ub; oh = t[63:32]; ol = t[31:0]; return MULT_CYCLES; end
      3'd3: begin
        if (b != 0) begin t = sa / sb; r = sa % sb; oh = r[31:0]; ol = t[31:0]; end
        return DIV_CYCLES;
      end
      3'd4: begin
        if (b != 0) begin t = ua / ub; r = ua % ub; oh = r[31:0]; ol = t[31:0]; end
        return DIV_CYCLES;
      end
      3'd5: begin oh = a; return 0; end
      3'd6: begin ol = a; return 0; end
      default: return 0;
    endcase
  endfunction

  // Entered and left at posedge+1. Checks stall, busy length, HI/LO hold and commit.
  task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic duse,
                       input logic [31:0] e_hi, input logic [31:0] e_lo, input int n);
    int cnt;
    int guard;
    logic exp_stall;
    start    = 1'b1;
    md_op    = op;
    rs_val   = a;
    rt_val   = b;
    d_md_use = duse;
    exp_stall = duse && (op >= 3'd1) && (op <= 3'd4);
    #1;
    check({name, " stall_start"}, stall_d, exp_stall);
    @(posedge clk); #1;
    start = 1'b0;
    md_op = 3'd0;
    cnt   = 0;
    guard = 0;
    while (busy === 1'b1 && guard < 64) begin
      cnt++;
      guard++;
      check({name, " hold_hi"}, hi, m_hi);
      check({name, " hold_lo"}, lo, m_lo);
      check({name, " stall_busy"}, stall_d, duse);
      @(posedge clk); #1;
    end
    check({name, " cycles"}, cnt, n);
    check({name, " stall_after"}, stall_d, 1'b0);
    check({name, " hi"}, hi, e_hi);
    check({name, " lo"}, lo, e_lo);
    m_hi = e_hi;
    m_lo = e_lo;
    d_md_use = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cnt;
    int          guard;
    int          n;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e_hi;
    logic [31:0] e_lo;

    vecs[0]  = '{"mult",      3'd1, 32'd3,          32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
    vecs[1]  = '{"div",       3'd3, 32'd7,          32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10};
    vecs[2]  = '{"divu",      3'd4, 32'hFFFF_FFFF,  32'd2,         32'h0000_0001, 32'h7FFF_FFFF, 10};
    vecs[3]  = '{"mthi",      3'd5, 32'h11,         32'd0,         32'h0000_0011, 32'h7FFF_FFFF, 0};
    vecs[4]  = '{"mtlo",      3'd6, 32'h22,         32'd0,         32'h0000_0011, 32'h0000_0022, 0};
    vecs[5]  = '{"div0",      3'd3, 32'd5,          32'd0,         32'h0000_0011, 32'h0000_0022, 10};
    vecs[6]  = '{"divu0",     3'd4, 32'd5,          32'd0,         32'h0000_0011, 32'h0000_0022, 10};
    vecs[7]  = '{"div_ovf",   3'd3, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10};
    vecs[8]  = '{"multu_max", 3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5};
    vecs[9]  = '{"op7",       3'd7, 32'd1,          32'd2,         32'hFFFF_FFFE, 32'h0000_0001, 0};
    vecs[10] = '{"div_neg",   3'd3, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[11] = '{"op0",       3'd0, 32'd9,          32'd9,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 0};

    reset    = 1'b0;
    start    = 1'b0;
    md_op    = 3'd0;
    rs_val   = 32'd0;
    rt_val   = 32'd0;
    d_md_use = 1'b0;
    m_hi     = 32'd0;
    m_lo     = 32'd0;
    #12;
    check("reset busy", busy, 1'b0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    check("reset stall", stall_d, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++)
      do_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, 1'b0,
            vecs[i].e_hi, vecs[i].e_lo, vecs[i].cycles);

    // Stall through a mult while a second (ignored) divu start is presented.
    d_md_use = 1'b1;
    start    = 1'b1;
    md_op    = 3'd1;
    rs_val   = 32'd6;
    rt_val   = 32'd7;
    #1;
    check("seq stall_start", stall_d, 1'b1);
    @(posedge clk); #1;
    md_op  = 3'd4;
    rs_val = 32'd100;
    rt_val = 32'd3;
    cnt    = 0;
    guard  = 0;
    while (busy === 1'b1 && guard < 64) begin
      cnt++;
      guard++;
      check("seq stall_busy", stall_d, 1'b1);
      if (cnt == 2) begin
        start = 1'b0;
        md_op = 3'd0;
      end
      @(posedge clk); #1;
    end
    check("seq cycles", cnt, MULT_CYCLES);
    check("seq stall_after", stall_d, 1'b0);
    check("seq hi", hi, 32'd0);
    check("seq lo", lo, 32'd42);
    m_hi = 32'd0;
    m_lo = 32'd42;
    d_md_use = 1'b0;

    // Asynchronous reset in busy cycle 4 of a divu.
    start  = 1'b1;
    md_op  = 3'd4;
    rs_val = 32'd100;
    rt_val = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    md_op = 3'd0;
    check("rst busy_c1", busy, 1'b1);
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("rst busy_now", busy, 1'b0);
    check("rst hi_now", hi, 32'd0);
    check("rst lo_now", lo, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      check("rst no_busy", busy, 1'b0);
    end
    check("rst hi_after", hi, 32'd0);
    check("rst lo_after", lo, 32'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;

    // Random operations against the model.
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 5) == 0) b = 32'hFFFF_FFFF;
      n  = model_op(op, a, b, m_hi, m_lo, e_hi, e_lo);
      do_op("rand", op, a, b, 1'($urandom_range(0, 1)), e_hi, e_lo, n);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
